// File: rtl/ff_fifo_push_arbiter.sv
// ff_fifo_push_arbiter: round-robin arbiter that shares one FIFO write port
// between n_req producers, granting bursts of up to max_burst pushes.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   req_valid/ready   per-requester valid/ready handshake (ready is combinational)
//   req_data          requester i's word in bits [i*width +: width]
//   fifo_push         combinational push to the FIFO (same cycle as transfer)
//   fifo_write_data   data of the transferring requester, 0 when idle
//   fifo_full         FIFO full flag; blocks every transfer
//   owner_valid       registered: a burst is in progress
//   owner_id          registered: current burst owner, 0 when none
module ff_fifo_push_arbiter #(
  parameter int unsigned width     = 8,
  parameter int unsigned n_req     = 4,
  parameter int unsigned max_burst = 4,
  localparam int unsigned id_w     = $clog2(n_req)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [n_req-1:0]       req_valid,
  input  logic [n_req*width-1:0] req_data,
  output logic [n_req-1:0]       req_ready,
  output logic                   fifo_push,
  output logic [width-1:0]       fifo_write_data,
  input  logic                   fifo_full,
  output logic                   owner_valid,
  output logic [id_w-1:0]        owner_id
);

  localparam int unsigned cnt_w = 8;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [id_w-1:0]   rr_ptr_q, rr_ptr_d;
  logic [id_w-1:0]   owner_q, owner_d;
  logic [cnt_w-1:0]  count_q, count_d;
  logic              owner_valid_q, owner_valid_d;
  logic [id_w-1:0]   owner_id_q, owner_id_d;

  logic              pick_found;
  logic [id_w-1:0]   pick_idx;
  logic [n_req-1:0]  xfer;
  logic              burst_done;

  // Index increment that wraps at n_req, also for non-power-of-two n_req.
  function automatic logic [id_w-1:0] wrap_inc(input logic [id_w-1:0] x);
    if (32'(x) == n_req - 1) return '0;
    return x + id_w'(1);
  endfunction

  // First valid requester scanning upward from rr_ptr, modulo n_req.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < n_req; k++) begin
      logic [id_w-1:0] idx;
      idx = id_w'((32'(rr_ptr_q) + k) % n_req);
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  // Widened so max_burst up to 255 compares without overflow.
  assign burst_done = ((9'(count_q) + 9'd1) == 9'(max_burst));

  // Next-state and combinational handshake.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    count_d   = count_q;
    req_ready = '0;
    unique case (state_q)
      ARB: begin
        if (pick_found && !fifo_full) begin
          req_ready[pick_idx] = 1'b1;
          if (max_burst == 1) begin
            rr_ptr_d = wrap_inc(pick_idx);
          end else begin
            owner_d = pick_idx;
            count_d = cnt_w'(1);
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        req_ready[owner_q] = ~fifo_full;
        if (!req_valid[owner_q]) begin
          // Owner went idle: release immediately so the next cycle re-arbitrates.
          rr_ptr_d = wrap_inc(owner_q);
          count_d  = '0;
          state_d  = ARB;
        end else if (!fifo_full) begin
          if (burst_done) begin
            rr_ptr_d = wrap_inc(owner_q);
            count_d  = '0;
            state_d  = ARB;
          end else begin
            count_d = count_q + cnt_w'(1);
          end
        end
      end
      default: state_d = ARB;
    endcase
    if (rst) req_ready = '0;
    owner_valid_d = (state_d == HOLD);
    owner_id_d    = (state_d == HOLD) ? owner_d : '0;
  end

  assign xfer      = req_valid & req_ready;
  assign fifo_push = |xfer;

  // Write-data mux; at most one xfer bit is set, so OR-ing the slices is exact.
  always_comb begin
    fifo_write_data = '0;
    for (int unsigned i = 0; i < n_req; i++) begin
      if (xfer[i]) fifo_write_data = fifo_write_data | req_data[i*width +: width];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      count_q       <= '0;
      owner_valid_q <= 1'b0;
      owner_id_q    <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      count_q       <= count_d;
      owner_valid_q <= owner_valid_d;
      owner_id_q    <= owner_id_d;
    end
  end

  assign owner_valid = owner_valid_q;
  assign owner_id    = owner_id_q;

endmodule
